// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage: 32-step shift-add
// multiply and restoring divide, with a stall request held until the result lands.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
  localparam logic [5:0]       LastCnt = 6'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Launch-time decode of the incoming operation.
  logic             in_div, in_rem;
  logic             signed_a, signed_b;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_launch;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    in_div   = funct3[2];
    in_rem   = funct3[2] & funct3[1];
    // MULH, MULHSU, DIV, REM treat op_a as signed; MULH, DIV, REM treat op_b as signed.
    signed_a = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) |
               (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
    sign_a   = signed_a & op_a[WIDTH-1];
    sign_b   = signed_b & op_b[WIDTH-1];
    mag_a    = sign_a ? (~op_a + 1'b1) : op_a;
    mag_b    = sign_b ? (~op_b + 1'b1) : op_b;
    neg_launch = in_rem ? sign_a : (sign_a ^ sign_b);

    div_zero = in_div & (op_b == '0);
    div_ovf  = in_div & ~funct3[0] & (op_a == MinNeg) & (op_b == AllOnes);
    if (div_zero) begin
      special_res = in_rem ? op_a : AllOnes;
    end else begin
      special_res = in_rem ? '0 : MinNeg;
    end
  end

  // One iteration of each datapath.
  logic             is_div_q;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_qbit;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    is_div_q = f3_q[2];

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // The shifted partial remainder needs one extra bit before the trial subtract.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    div_qbit  = ~div_trial[WIDTH];
    div_rem   = div_qbit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_qbit};
  end

  // Sign fix-up and result selection.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    unique case (f3_q)
      3'b000:                 fix_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;

    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          f3_d  = funct3;
          neg_d = neg_launch;
          cnt_d = '0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = StDone;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            b_d     = mag_b;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StFix;
        end
      end
      StFix: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A killed instruction abandons its work and leaves the old result in place.
    if (flush && (state_q != StIdle)) begin
      state_d  = StIdle;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      f3_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign stall_req = ((state_q == StIdle) & start & ~flush) | (state_q == StCalc) |
                     (state_q == StFix);
  assign done      = (state_q == StDone);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, stall window, results, special cases,
// flush, asynchronous reset and back-to-back launches.
module tb_muldiv_seq;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall_req;
  logic        done;
  logic [31:0] result;

  int n_chk;
  int n_bad;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Launch one op in IDLE (cycle 0), run until done, then step back into IDLE.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int stall_cnt;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    #1;
    check_eq({tag, ".stall0"}, 32'(stall_req), 32'd1);
    lat       = -1;
    stall_cnt = 1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        check_eq({tag, ".stall_at_done"}, 32'(stall_req), 32'd0);
        start = 1'b0;
      end else if (stall_req) begin
        stall_cnt++;
      end
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
    check_eq({tag, ".result"}, result, exp);
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_done;
    int t1;
    int t2;
    logic [31:0] r1;
    logic [31:0] r2;

    n_chk  = 0;
    n_bad  = 0;
    rstn   = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    #2;
    check_eq("reset.done", 32'(done), 32'd0);
    check_eq("reset.stall", 32'(stall_req), 32'd0);
    check_eq("reset.result", result, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    do_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    do_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);
    do_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);

    // Flush a DIV in cycle 10; the previous result (2) must survive.
    funct3 = 3'b100;
    op_a   = 32'd100;
    op_b   = 32'd7;
    start  = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush.stall", 32'(stall_req), 32'd0);
    check_eq("flush.done", 32'(done), 32'd0);
    check_eq("flush.result", result, 32'd2);
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check_eq("flush.no_done", 32'(n_done), 32'd0);
    do_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_zero", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    do_op("divu_zero", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);

    // Asynchronous reset in cycle 20 of a MUL.
    funct3 = 3'b000;
    op_a   = 32'd5;
    op_b   = 32'd6;
    start  = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    #2;
    start = 1'b0;
    rstn  = 1'b0;
    #1;
    check_eq("rst.result", result, 32'd0);
    check_eq("rst.stall", 32'(stall_req), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    #1;
    rstn   = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check_eq("rst.no_done", 32'(n_done), 32'd0);

    // Back-to-back MULs with start held through DONE.
    funct3 = 3'b000;
    op_a   = 32'd3;
    op_b   = 32'd5;
    start  = 1'b1;
    n_done = 0;
    t1     = -1;
    t2     = -1;
    r1     = '0;
    r2     = '0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          t1   = c;
          r1   = result;
          op_a = 32'd2;
          op_b = 32'd9;
        end else if (n_done == 2) begin
          t2    = c;
          r2    = result;
          start = 1'b0;
        end
      end
    end
    check_eq("b2b.count", 32'(n_done), 32'd2);
    check_eq("b2b.first_lat", 32'(t1), 32'd34);
    check_eq("b2b.gap", 32'(t2 - t1), 32'd35);
    check_eq("b2b.r1", r1, 32'd15);
    check_eq("b2b.r2", r2, 32'd18);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32M multiply/divide datapath in the EX stage. It accepts one M-extension operation at a time, computes it over a fixed number of cycles, and drives a stall request into the pipeline hazard logic until the result is ready. It replaces a single-cycle multiplier/divider, so the forwarding path sees a finished result only when `done` is high.

## Interface
- `WIDTH`, default 32: operand/result width; only 32 is supported.
- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `rstn`  input  1  asynchronous, active-low reset.
- `start`  input  1  EX holds a valid M-extension op (opcode 0110011, funct7 0000001). Held high by the pipeline while stalled.
- `funct3`  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  input  32  rs1 value after forwarding.
- `op_b`  input  32  rs2 value after forwarding.
- `flush`  input  1  EX instruction is being killed by a branch/jump redirect.
- `stall_req`  output  1  hold PC, IF/ID and ID/EX; combinational.
- `done`  output  1  one-cycle pulse; `result` is valid this cycle.
- `result`  output  32  registered result; holds its value until the next completion.

## Operation
- **States:** IDLE, CALC, FIX, DONE. A 6-bit iteration counter and internal registers hold the operands, a 64-bit accumulator/remainder, and sign flags.
- **IDLE, start=1, flush=0:** latch funct3. Latch |op_a| and |op_b|, where an operand is signed-abs'd if it is signed for that op (MULH/DIV/REM: both; MULHSU: op_a only). Record the result sign. Go to CALC with counter=0.
- **Result sign:**
  - MUL-family: sign(a) XOR sign(b).
  - DIV: sign(a) XOR sign(b).
  - REM: sign(a).
- **Special cases, detected in IDLE; go straight to DONE with the value precomputed into `result`:**
  - Divide by zero (op_b=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- **CALC, one step per cycle for 32 cycles (counter 0..31):**
  - Multiply: radix-2 shift-add of the magnitudes into the 64-bit product.
  - Divide: restoring shift-subtract producing quotient and remainder magnitudes.
  - At counter=31, go to FIX.
- **FIX:** negate the selected half if the sign flag is set. Load `result`:
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Go to DONE.
- **DONE:** `done`=1. Always return to IDLE next cycle. `start` is ignored in DONE because it still belongs to the completing instruction.
- **stall_req** = (IDLE & start & ~flush) | CALC | FIX. It is 0 in DONE and in IDLE without start.
- **flush:** in any state other than IDLE, go to IDLE next edge. The counter clears, `done` is not asserted, and `result` is unchanged. A flush has priority over start in IDLE (no launch).
- **Reset (rstn=0):** immediately forces IDLE, counter=0, `result`=0, and all internal registers to 0. Therefore `stall_req`=0 (absent start) and `done`=0. Reset mid-operation discards the operation.

## Timing
- Normal op, `start` first seen in IDLE at cycle 0:
  - CALC in cycles 1–32.
  - FIX in cycle 33.
  - DONE in cycle 34.
  - `stall_req` is high in cycles 0–33 and low in cycle 34.
  - Total latency is 34 cycles.
- Special-case op: `stall_req` is high in cycle 0 only; `done` is high in cycle 1.
- Back-to-back M ops: the next instruction's `start` is seen in IDLE in cycle 35 and launches with no idle gap beyond that.
- Latency is independent of operand values (no early termination except the special cases).
- All arithmetic is unsigned on magnitudes. The negation of 0x80000000 magnitude (MULH extremes) must use the 33-bit/64-bit intermediate widths so no overflow is lost.

## Test plan
1. **MUL:** op_a=7, op_b=0xFFFFFFFD, funct3=000 → `done` at cycle 34 with `result`=0xFFFFFFEB; `stall_req` high exactly in cycles 0–33.
2. **High-half multiplies, op_a=op_b=0xFFFFFFFF:** MULHU → 0xFFFFFFFE; MULH → 0x00000000; MULHSU → 0xFFFFFFFF. Also MULH 0x80000000×0x80000000 → 0x40000000.
3. **Divides:** DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU with the same operands → 0x7FFFFFFC; REMU 100/7 → 2. All complete at cycle 34.
4. **Special cases, each with `done` at cycle 1:**
   - DIVU 5/0 → 0xFFFFFFFF.
   - REM 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
   - REM with the same operands → 0.
5. **Flush:** flush asserted in cycle 10 of a DIV → IDLE at cycle 11, `stall_req`=0, no `done`, `result` keeps its prior value. A following MUL 3×4 → 12 at its cycle 34.
6. **Reset and back-to-back:**
   - rstn pulsed low in cycle 20 of a MUL → `result`=0, `stall_req`=0, `done`=0 asynchronously, no later `done`.
   - Two back-to-back MULs with `start` held through DONE → exactly two `done` pulses, 35 cycles apart.
